fizzle_fade: RTL and testbench

//  Parametrised LFSR "fizzlefade" engine: overwrites every framebuffer pixel exactly once, in

---
 rtl/fizzle_fade.sv | 106 ++++++++++
 tb/tb_fizzle_fade.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fizzle_fade.sv
// LFSR fizzle-fade engine: overwrites each framebuffer pixel exactly once, in
// pseudo-random order, with a latched fill colour index.
module fizzle_fade #(
  parameter int unsigned FB_WIDTH  = 160,
  parameter int unsigned FB_HEIGHT = 120,
  parameter int unsigned FB_DATAW  = 4,
  parameter int unsigned LFSR_LEN  = 15,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS = 15'b110000000000000,
  parameter int unsigned FADE_WAIT = 600,
  parameter int unsigned FADE_RATE = 3200,
  parameter int unsigned FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                frame,
  input  logic [FB_DATAW-1:0] colr_in,
  output logic                busy,
  output logic                done,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr,
  output logic [FB_DATAW-1:0] fb_cidx
);

  localparam int unsigned FB_PIX = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned WAIT_W = (FADE_WAIT > 1) ? $clog2(FADE_WAIT + 1) : 1;
  localparam int unsigned RATE_W = (FADE_RATE > 1) ? $clog2(FADE_RATE) : 1;
  localparam logic [LFSR_LEN-1:0] SEED = LFSR_LEN'(1);

  typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;

  state_t              state;
  logic [LFSR_LEN-1:0] lfsr;
  logic [LFSR_LEN-1:0] lfsr_next;
  logic [LFSR_LEN-1:0] cand;
  logic                in_range;
  logic                step;
  logic [FB_DATAW-1:0] colr;
  logic [WAIT_W-1:0]   cnt_wait;
  logic [RATE_W-1:0]   cnt_rate;

  // Candidate address is lfsr-1, so the seed maps to pixel 0.
  assign lfsr_next = {lfsr[LFSR_LEN-2:0], ^(lfsr & LFSR_TAPS)};
  assign cand      = lfsr - SEED;
  assign in_range  = (cand < LFSR_LEN'(FB_PIX));
  assign step      = (cnt_rate == RATE_W'(FADE_RATE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_cidx  <= '0;
      lfsr     <= SEED;
      colr     <= '0;
      cnt_wait <= '0;
      cnt_rate <= '0;
    end else begin
      fb_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (start) begin
            state    <= WAIT;
            busy     <= 1'b1;
            colr     <= colr_in;
            lfsr     <= SEED;
            cnt_wait <= '0;
            cnt_rate <= '0;
          end
        end
        WAIT: begin
          if (FADE_WAIT == 0) begin
            state <= RUN;
          end else if (frame) begin
            cnt_wait <= cnt_wait + WAIT_W'(1);
            if (cnt_wait == WAIT_W'(FADE_WAIT - 1)) state <= RUN;
          end
        end
        RUN: begin
          if (step) begin
            lfsr <= lfsr_next;
            // Skipped candidates keep cnt_rate at the step value so the next one is tried at once.
            if (in_range) begin
              fb_we    <= 1'b1;
              fb_addr  <= FB_ADDRW'(cand);
              fb_cidx  <= colr;
              cnt_rate <= '0;
            end
            if (lfsr_next == SEED) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            cnt_rate <= cnt_rate + RATE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fizzle_fade.sv
// Directed self-checking bench for fizzle_fade: small 4x3 configs plus a full-size scoreboard run.
module tb_fizzle_fade;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, frame_a, start_b, start_c;
  logic [3:0] colr_a, colr_b, colr_c;
  logic busy_a, done_a, we_a, busy_b, done_b, we_b, busy_c, done_c, we_c;
  logic [3:0] addr_a, cidx_a, addr_b, cidx_b, cidx_c;
  logic [14:0] addr_c;
  logic frame_zero;

  assign frame_zero = 1'b0;

  fizzle_fade #(.FB_WIDTH(4), .FB_HEIGHT(3), .FB_DATAW(4), .LFSR_LEN(4),
                .LFSR_TAPS(4'b1100), .FADE_WAIT(2), .FADE_RATE(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .frame(frame_a), .colr_in(colr_a),
    .busy(busy_a), .done(done_a), .fb_we(we_a), .fb_addr(addr_a), .fb_cidx(cidx_a));

  fizzle_fade #(.FB_WIDTH(4), .FB_HEIGHT(3), .FB_DATAW(4), .LFSR_LEN(4),
                .LFSR_TAPS(4'b1100), .FADE_WAIT(0), .FADE_RATE(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .frame(frame_zero), .colr_in(colr_b),
    .busy(busy_b), .done(done_b), .fb_we(we_b), .fb_addr(addr_b), .fb_cidx(cidx_b));

  fizzle_fade #(.FADE_WAIT(0), .FADE_RATE(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .frame(frame_zero), .colr_in(colr_c),
    .busy(busy_c), .done(done_c), .fb_we(we_c), .fb_addr(addr_c), .fb_cidx(cidx_c));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame;
    frame_a = 1'b1;
    tick();
    frame_a = 1'b0;
  endtask

  int exp_addr [12] = '{0, 1, 3, 8, 2, 5, 9, 4, 10, 6, 11, 7};
  int exp_gap  [11] = '{2, 2, 2, 2, 2, 3, 2, 2, 2, 4, 2};
  int exp_rel  [12] = '{2, 3, 4, 5, 6, 7, 9, 10, 11, 12, 15, 16};
  int wcyc [12];
  bit seen [19200];

  initial begin
    int cyc, nw, nwe, badc, dcount, dups, oor, missing;
    logic got_done, done_we, done_busy;
    logic [3:0] done_addr;

    rst = 1'b1; start_a = 0; start_b = 0; start_c = 0; frame_a = 0;
    colr_a = 0; colr_b = 0; colr_c = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_we", 32'(we_a), 0);
    check("rst_addr", 32'(addr_a), 0);
    check("rst_cidx", 32'(cidx_a), 0);

    // Fade 1: colour 5, start/colour noise while busy must be ignored
    colr_a = 4'd5; start_a = 1'b1;
    tick();
    start_a = 1'b0; colr_a = 4'd3;
    check("busy_after_start", 32'(busy_a), 1);
    nwe = 0;
    for (int i = 0; i < 8; i++) begin
      start_a = ~start_a;
      tick();
      if (we_a) nwe++;
    end
    start_a = 1'b0;
    check("no_write_no_frame", 32'(nwe), 0);
    pulse_frame();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (we_a) nwe++;
    end
    check("no_write_one_frame", 32'(nwe), 0);
    pulse_frame();

    cyc = 0; nw = 0; badc = 0; dcount = 0; got_done = 0;
    done_we = 0; done_addr = 0; done_busy = 0;
    while (!got_done && cyc < 200) begin
      tick();
      cyc++;
      if (we_a) begin
        if (nw < 12) begin
          check($sformatf("f1_addr%0d", nw), 32'(addr_a), 32'(exp_addr[nw]));
          wcyc[nw] = cyc;
        end
        if (cidx_a !== 4'd5) badc++;
        nw++;
      end
      if (done_a) begin
        got_done = 1; dcount++;
        done_we = we_a; done_addr = addr_a; done_busy = busy_a;
        start_a = 1'b0;
      end else begin
        start_a = (cyc % 5 == 0);
        colr_a  = 4'(cyc);
        frame_a = (cyc % 3 == 0);
      end
    end
    frame_a = 1'b0;
    check("f1_done_seen", 32'(got_done), 1);
    check("f1_write_count", 32'(nw), 12);
    check("f1_cidx_bad", 32'(badc), 0);
    check("f1_first_write_cyc", 32'(wcyc[0]), 2);
    check("f1_done_with_we", 32'(done_we), 1);
    check("f1_done_addr", 32'(done_addr), 7);
    check("f1_busy_at_done", 32'(done_busy), 1);
    for (int i = 0; i < 11; i++)
      check($sformatf("f1_gap%0d", i + 1), 32'(wcyc[i + 1] - wcyc[i]), 32'(exp_gap[i]));
    tick();
    check("f1_busy_after", 32'(busy_a), 0);
    check("f1_done_one_cycle", 32'(done_a), 0);
    check("f1_addr_hold", 32'(addr_a), 7);
    check("f1_we_idle", 32'(we_a), 0);

    // Fade 2: reset after fifth write, then restart replays from address 0
    colr_a = 4'd9; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    pulse_frame();
    tick();
    pulse_frame();
    cyc = 0; nw = 0;
    while (nw < 5 && cyc < 100) begin
      tick();
      cyc++;
      if (we_a) nw++;
    end
    check("f2_five_writes", 32'(nw), 5);
    check("f2_cidx", 32'(cidx_a), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("f2_rst_busy", 32'(busy_a), 0);
    check("f2_rst_we", 32'(we_a), 0);
    nwe = 0;
    repeat (20) begin
      tick();
      if (we_a) nwe++;
    end
    check("f2_no_write_after_rst", 32'(nwe), 0);
    check("f2_idle_busy", 32'(busy_a), 0);

    colr_a = 4'd9; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    pulse_frame();
    tick();
    pulse_frame();
    cyc = 0; nw = 0;
    while (nw < 2 && cyc < 100) begin
      tick();
      cyc++;
      if (we_a) begin
        check($sformatf("f3_addr%0d", nw), 32'(addr_a), 32'(exp_addr[nw]));
        check($sformatf("f3_cidx%0d", nw), 32'(cidx_a), 9);
        nw++;
      end
    end
    check("f3_writes_seen", 32'(nw), 2);

    // No wait, one step per clock
    colr_b = 4'd6; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 0; nw = 0; got_done = 0;
    while (!got_done && cyc < 50) begin
      tick();
      cyc++;
      if (we_b) begin
        if (nw < 12) begin
          check($sformatf("b_addr%0d", nw), 32'(addr_b), 32'(exp_addr[nw]));
          check($sformatf("b_cyc%0d", nw), 32'(cyc), 32'(exp_rel[nw]));
        end
        nw++;
      end
      if (done_b) got_done = 1;
    end
    check("b_done_seen", 32'(got_done), 1);
    check("b_done_cyc", 32'(cyc), 16);
    check("b_write_count", 32'(nw), 12);
    check("b_cidx", 32'(cidx_b), 6);

    // Full-size framebuffer scoreboard
    colr_c = 4'hA; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    cyc = 0; nw = 0; dups = 0; oor = 0; badc = 0; got_done = 0;
    while (!got_done && cyc < 40000) begin
      tick();
      cyc++;
      if (we_c) begin
        if (nw == 0) check("c_first_addr", 32'(addr_c), 0);
        if (addr_c >= 15'd19200) oor++;
        else if (seen[addr_c]) dups++;
        else seen[addr_c] = 1'b1;
        if (cidx_c !== 4'hA) badc++;
        nw++;
      end
      if (done_c) got_done = 1;
    end
    missing = 0;
    for (int i = 0; i < 19200; i++) if (!seen[i]) missing++;
    check("c_done_seen", 32'(got_done), 1);
    check("c_write_count", 32'(nw), 19200);
    check("c_dups", 32'(dups), 0);
    check("c_out_of_range", 32'(oor), 0);
    check("c_missing", 32'(missing), 0);
    check("c_cidx_bad", 32'(badc), 0);
    check("c_done_cyc", 32'(cyc), 32768);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
